// File: rtl/iq_freelist_ctrl.sv
// iq_freelist_ctrl
// Circular free list of issue-queue entry indices. Dispatch pops up to
// DISPATCH_WIDTH free indices per cycle. Issue returns up to ISSUE_WIDTH
// indices per cycle, compacted in ascending lane order.
//
// Ports:
//   clk              clock
//   reset            asynchronous, active-high reset
//   flush_i          restores the full free list (pipeline recovery)
//   dispatchValid_i  per-lane pop request, contiguous from lane 0
//   freeEntry_o      lane i = store[(head+i) mod DEPTH], combinational
//   stall_o          request exceeds the registered free count
//   freedValid_i     per-lane push valid, any mask
//   freedEntry_i     index returned on each push lane
//   count_o          number of free entries, 0..DEPTH
//   overflow_o       sticky flag: a push would have exceeded DEPTH
module iq_freelist_ctrl #(
    parameter int DEPTH          = 32,
    parameter int INDEX          = 5,
    parameter int DISPATCH_WIDTH = 4,
    parameter int ISSUE_WIDTH    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush_i,
    input  logic [DISPATCH_WIDTH-1:0]       dispatchValid_i,
    output logic [DISPATCH_WIDTH*INDEX-1:0] freeEntry_o,
    output logic                            stall_o,
    input  logic [ISSUE_WIDTH-1:0]          freedValid_i,
    input  logic [ISSUE_WIDTH*INDEX-1:0]    freedEntry_i,
    output logic [INDEX:0]                  count_o,
    output logic                            overflow_o
);

    localparam int CNT_W = INDEX + 1;
    // One extra bit so count - granted + pushed can exceed DEPTH without wrapping.
    localparam int SUM_W = INDEX + 2;

    logic [INDEX-1:0] store [DEPTH];
    logic [INDEX-1:0] head;
    logic [INDEX-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic [SUM_W-1:0] n_req;
    logic [SUM_W-1:0] n_push;
    logic [SUM_W-1:0] granted;
    logic [SUM_W-1:0] count_next;
    logic             pop_fire;
    logic             push_drop;

    logic [INDEX-1:0] prefix;
    logic [INDEX-1:0] lane_addr [ISSUE_WIDTH];
    logic [DEPTH-1:0] wr_en;
    logic [INDEX-1:0] wr_data [DEPTH];

    always_comb begin
        n_req  = '0;
        n_push = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            n_req = n_req + SUM_W'(dispatchValid_i[i]);
        end
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            n_push = n_push + SUM_W'(freedValid_i[l]);
        end
    end

    // Stall looks only at the registered count; same-cycle pushes cannot help.
    assign stall_o    = n_req > SUM_W'(count);
    assign pop_fire   = (n_req != '0) && !stall_o && !flush_i;
    assign granted    = pop_fire ? n_req : '0;
    assign count_next = SUM_W'(count) - granted + n_push;
    assign push_drop  = count_next > SUM_W'(DEPTH);

    // Prefix popcount: each valid lane gets the next free slot after tail.
    always_comb begin
        prefix = '0;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            lane_addr[l] = tail + prefix;
            prefix       = prefix + INDEX'(freedValid_i[l]);
        end
    end

    // Compacted addresses are unique, so an OR of matching lanes is a safe mux.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            wr_en[e]   = 1'b0;
            wr_data[e] = '0;
            for (int l = 0; l < ISSUE_WIDTH; l++) begin
                if (freedValid_i[l] && (lane_addr[l] == INDEX'(e))) begin
                    wr_en[e]   = 1'b1;
                    wr_data[e] = wr_data[e] | freedEntry_i[l*INDEX +: INDEX];
                end
            end
        end
    end

    always_comb begin
        freeEntry_o = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            freeEntry_o[i*INDEX +: INDEX] = store[head + INDEX'(i)];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                store[e] <= INDEX'(e);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
            ovf   <= 1'b0;
        end else if (flush_i) begin
            for (int e = 0; e < DEPTH; e++) begin
                store[e] <= INDEX'(e);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
            ovf   <= 1'b0;
        end else begin
            head <= head + INDEX'(granted);
            if (push_drop) begin
                // Whole push discarded; a granted pop still retires.
                count <= count - CNT_W'(granted);
                ovf   <= 1'b1;
            end else begin
                count <= CNT_W'(count_next);
                tail  <= tail + INDEX'(n_push);
                for (int e = 0; e < DEPTH; e++) begin
                    if (wr_en[e]) begin
                        store[e] <= wr_data[e];
                    end
                end
            end
        end
    end

    assign count_o    = count;
    assign overflow_o = ovf;

    // Requests must be a run of ones starting at lane 0.
    contiguous_dispatch: assert property (@(posedge clk) disable iff (reset)
        ((dispatchValid_i & (dispatchValid_i + DISPATCH_WIDTH'(1))) == '0));

endmodule

// File: tb/tb_iq_freelist_ctrl.sv
// tb_iq_freelist_ctrl
// Exercises the free-list controller against a queue model: the model keeps
// the free indices in pop order, plus the set of indices currently held by
// the issue queue so that returned indices are always real ones.
module tb_iq_freelist_ctrl;

    localparam int DEPTH = 32;
    localparam int INDEX = 5;
    localparam int DW    = 4;
    localparam int IW    = 4;

    logic                clk;
    logic                reset;
    logic                flush_i;
    logic [DW-1:0]       dispatchValid_i;
    logic [DW*INDEX-1:0] freeEntry_o;
    logic                stall_o;
    logic [IW-1:0]       freedValid_i;
    logic [IW*INDEX-1:0] freedEntry_i;
    logic [INDEX:0]      count_o;
    logic                overflow_o;

    int n_checks = 0;
    int n_pass   = 0;

    int q[$];
    int inuse[$];
    bit m_ovf;

    iq_freelist_ctrl #(
        .DEPTH(DEPTH), .INDEX(INDEX), .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(IW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush_i(flush_i),
        .dispatchValid_i(dispatchValid_i),
        .freeEntry_o(freeEntry_o),
        .stall_o(stall_o),
        .freedValid_i(freedValid_i),
        .freedEntry_i(freedEntry_i),
        .count_o(count_o),
        .overflow_o(overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        q.delete();
        inuse.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(i);
        m_ovf = 1'b0;
    endfunction

    function automatic int take_inuse();
        int idx;
        int v;
        idx = $urandom_range(0, inuse.size() - 1);
        v = inuse[idx];
        inuse.delete(idx);
        return v;
    endfunction

    function automatic void inuse_remove(input int v);
        for (int i = 0; i < inuse.size(); i++) begin
            if (inuse[i] == v) begin
                inuse.delete(i);
                return;
            end
        end
    endfunction

    function automatic int lane(input int i);
        return int'(freeEntry_o[i*INDEX +: INDEX]);
    endfunction

    task automatic drive(input logic [DW-1:0] dv, input logic [IW-1:0] fv,
                         input logic [IW*INDEX-1:0] fe, input logic fl);
        dispatchValid_i = dv;
        freedValid_i    = fv;
        freedEntry_i    = fe;
        flush_i         = fl;
    endtask

    // Apply this cycle's inputs to the model, then step past the clock edge.
    task automatic advance();
        int nreq;
        int npush;
        int granted;
        int v;
        nreq  = $countones(dispatchValid_i);
        npush = $countones(freedValid_i);
        if (flush_i) begin
            model_reset();
        end else begin
            granted = (nreq > 0 && nreq <= q.size()) ? nreq : 0;
            for (int k = 0; k < granted; k++) begin
                v = q.pop_front();
                inuse.push_back(v);
            end
            if (q.size() + npush > DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                for (int l = 0; l < IW; l++) begin
                    if (freedValid_i[l]) q.push_back(int'(freedEntry_i[l*INDEX +: INDEX]));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive('0, '0, '0, 1'b0);
        #3;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive('0, '0, '0, 1'b0);
        #2;
        n_checks++;
        if (count_o !== 6'd32) $display("[TB] FAIL reset_count: got %0d expected 32", count_o);
        else n_pass++;
        n_checks++;
        if (overflow_o !== 1'b0) $display("[TB] FAIL reset_ovf: got %0b expected 0", overflow_o);
        else n_pass++;
        n_checks++;
        if (stall_o !== 1'b0) $display("[TB] FAIL reset_stall: got %0b expected 0", stall_o);
        else n_pass++;
        for (int i = 0; i < DW; i++) begin
            n_checks++;
            if (lane(i) !== i) $display("[TB] FAIL reset_lane%0d: got %0d expected %0d", i, lane(i), i);
            else n_pass++;
        end
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (count_o !== 6'd32) $display("[TB] FAIL reset_idle_count: got %0d expected 32", count_o);
        else n_pass++;
    endtask

    task automatic test_first_pop();
        do_reset();
        drive(4'b1111, '0, '0, 1'b0);
        #1;
        n_checks++;
        if (stall_o !== 1'b0) $display("[TB] FAIL first_pop_stall: got %0b expected 0", stall_o);
        else n_pass++;
        for (int i = 0; i < DW; i++) begin
            n_checks++;
            if (lane(i) !== i) $display("[TB] FAIL first_pop_lane%0d: got %0d expected %0d", i, lane(i), i);
            else n_pass++;
        end
        advance();
        drive('0, '0, '0, 1'b0);
        #1;
        n_checks++;
        if (count_o !== 6'd28) $display("[TB] FAIL first_pop_count: got %0d expected 28", count_o);
        else n_pass++;
        for (int i = 0; i < DW; i++) begin
            n_checks++;
            if (lane(i) !== i + 4) $display("[TB] FAIL second_lane%0d: got %0d expected %0d", i, lane(i), i + 4);
            else n_pass++;
        end
    endtask

    task automatic test_drain_stall();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(4'b1111, '0, '0, 1'b0);
            #1;
            n_checks++;
            if (stall_o !== 1'b0 || lane(0) !== q[0])
                $display("[TB] FAIL drain_pop%0d: got stall=%0b lane0=%0d expected stall=0 lane0=%0d",
                         c, stall_o, lane(0), q[0]);
            else n_pass++;
            advance();
        end
        n_checks++;
        if (count_o !== 6'd4) $display("[TB] FAIL drain_count4: got %0d expected 4", count_o);
        else n_pass++;
        drive(4'b0111, '0, '0, 1'b0);
        #1;
        n_checks++;
        if (stall_o !== 1'b0) $display("[TB] FAIL exact_grant_stall: got %0b expected 0", stall_o);
        else n_pass++;
        advance();
        n_checks++;
        if (count_o !== 6'd1) $display("[TB] FAIL exact_grant_count: got %0d expected 1", count_o);
        else n_pass++;
        drive(4'b0011, '0, '0, 1'b0);
        #1;
        n_checks++;
        if (stall_o !== 1'b1) $display("[TB] FAIL short_stall: got %0b expected 1", stall_o);
        else n_pass++;
        advance();
        drive('0, '0, '0, 1'b0);
        #1;
        n_checks++;
        if (count_o !== 6'd1 || lane(0) !== 31)
            $display("[TB] FAIL stall_hold: got count=%0d lane0=%0d expected count=1 lane0=31", count_o, lane(0));
        else n_pass++;
    endtask

    task automatic test_sparse_push();
        logic [IW*INDEX-1:0] fe;
        int v;
        do_reset();
        drive(4'b1111, '0, '0, 1'b0);
        advance();
        fe = {5'd2, 5'd17, 5'd0, 5'd17};
        inuse_remove(0);
        inuse_remove(2);
        drive('0, 4'b1010, fe, 1'b0);
        #1;
        n_checks++;
        if (count_o !== 6'd28) $display("[TB] FAIL sparse_pre_count: got %0d expected 28", count_o);
        else n_pass++;
        advance();
        drive('0, '0, '0, 1'b0);
        #1;
        n_checks++;
        if (count_o !== 6'd30) $display("[TB] FAIL sparse_count: got %0d expected 30", count_o);
        else n_pass++;
        for (int c = 0; c < 7; c++) begin
            drive(4'b1111, '0, '0, 1'b0);
            #1;
            for (int i = 0; i < DW; i++) begin
                n_checks++;
                if (lane(i) !== q[i]) $display("[TB] FAIL sparse_drain%0d_lane%0d: got %0d expected %0d", c, i, lane(i), q[i]);
                else n_pass++;
            end
            advance();
        end
        drive('0, '0, '0, 1'b0);
        #1;
        n_checks++;
        if (count_o !== 6'd2 || lane(0) !== 0 || lane(1) !== 2)
            $display("[TB] FAIL sparse_order: got count=%0d lanes=%0d,%0d expected count=2 lanes=0,2",
                     count_o, lane(0), lane(1));
        else n_pass++;
        drive(4'b0011, '0, '0, 1'b0);
        advance();
        // Empty list: a same-cycle push must not satisfy a request.
        v = take_inuse();
        fe = '0;
        fe[4:0] = 5'(v);
        drive(4'b0001, 4'b0001, fe, 1'b0);
        #1;
        n_checks++;
        if (stall_o !== 1'b1) $display("[TB] FAIL empty_stall: got %0b expected 1", stall_o);
        else n_pass++;
        advance();
        drive('0, '0, '0, 1'b0);
        #1;
        n_checks++;
        if (count_o !== 6'd1 || lane(0) !== v)
            $display("[TB] FAIL empty_refill: got count=%0d lane0=%0d expected count=1 lane0=%0d", count_o, lane(0), v);
        else n_pass++;
    endtask

    task automatic test_wrap_traffic();
        logic [DW-1:0]       dv;
        logic [IW-1:0]       fv;
        logic [IW*INDEX-1:0] fe;
        int len;
        int seen [DEPTH];
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, '0, '0, 1'b0);
            advance();
        end
        for (int c = 0; c < 8; c++) begin
            fe = '0;
            fv = (c < 7) ? 4'b1111 : 4'b0011;
            for (int l = 0; l < IW; l++) if (fv[l]) fe[l*INDEX +: INDEX] = 5'(take_inuse());
            drive('0, fv, fe, 1'b0);
            advance();
        end
        n_checks++;
        if (count_o !== 6'd30) $display("[TB] FAIL wrap_fill_count: got %0d expected 30", count_o);
        else n_pass++;
        drive(4'b1111, '0, '0, 1'b0);
        advance();
        fe = '0;
        for (int l = 0; l < IW; l++) fe[l*INDEX +: INDEX] = 5'(take_inuse());
        drive(4'b0011, 4'b1111, fe, 1'b0);
        #1;
        n_checks++;
        if (stall_o !== 1'b0) $display("[TB] FAIL wrap_push_stall: got %0b expected 0", stall_o);
        else n_pass++;
        advance();
        n_checks++;
        if (count_o !== 6'd28) $display("[TB] FAIL wrap_push_count: got %0d expected 28", count_o);
        else n_pass++;
        for (int c = 0; c < 64; c++) begin
            len = $urandom_range(0, 4);
            dv = 4'((1 << len) - 1);
            fv = '0;
            fe = '0;
            for (int l = 0; l < IW; l++) begin
                if ($urandom_range(0, 1) == 1 && inuse.size() > 0) begin
                    fv[l] = 1'b1;
                    fe[l*INDEX +: INDEX] = 5'(take_inuse());
                end
            end
            drive(dv, fv, fe, 1'b0);
            #1;
            n_checks++;
            if (stall_o !== (len > q.size()) || count_o !== 6'(q.size()) || overflow_o !== m_ovf)
                $display("[TB] FAIL traffic%0d: got stall=%0b count=%0d ovf=%0b expected stall=%0b count=%0d ovf=%0b",
                         c, stall_o, count_o, overflow_o, (len > q.size()), q.size(), m_ovf);
            else n_pass++;
            for (int i = 0; i < DW; i++) begin
                if (i < q.size()) begin
                    n_checks++;
                    if (lane(i) !== q[i]) $display("[TB] FAIL traffic%0d_lane%0d: got %0d expected %0d", c, i, lane(i), q[i]);
                    else n_pass++;
                end
            end
            advance();
        end
        while (inuse.size() > 0) begin
            fv = '0;
            fe = '0;
            for (int l = 0; l < IW; l++) begin
                if (inuse.size() > 0) begin
                    fv[l] = 1'b1;
                    fe[l*INDEX +: INDEX] = 5'(take_inuse());
                end
            end
            drive('0, fv, fe, 1'b0);
            advance();
        end
        n_checks++;
        if (count_o !== 6'd32) $display("[TB] FAIL traffic_refill_count: got %0d expected 32", count_o);
        else n_pass++;
        for (int v = 0; v < DEPTH; v++) seen[v] = 0;
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, '0, '0, 1'b0);
            #1;
            for (int i = 0; i < DW; i++) seen[lane(i)]++;
            advance();
        end
        for (int v = 0; v < DEPTH; v++) begin
            n_checks++;
            if (seen[v] !== 1) $display("[TB] FAIL unique_index%0d: got %0d copies expected 1", v, seen[v]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [IW*INDEX-1:0] fe;
        do_reset();
        drive('0, 4'b0001, {15'd0, 5'd7}, 1'b0);
        #1;
        n_checks++;
        if (overflow_o !== 1'b0) $display("[TB] FAIL ovf_pre: got %0b expected 0", overflow_o);
        else n_pass++;
        advance();
        drive('0, '0, '0, 1'b0);
        #1;
        n_checks++;
        if (overflow_o !== 1'b1 || count_o !== 6'd32)
            $display("[TB] FAIL ovf_set: got ovf=%0b count=%0d expected ovf=1 count=32", overflow_o, count_o);
        else n_pass++;
        advance();
        n_checks++;
        if (overflow_o !== 1'b1 || lane(0) !== 0)
            $display("[TB] FAIL ovf_sticky: got ovf=%0b lane0=%0d expected ovf=1 lane0=0", overflow_o, lane(0));
        else n_pass++;
        fe = 20'($urandom);
        drive(4'b0011, 4'b1111, fe, 1'b0);
        advance();
        drive('0, '0, '0, 1'b0);
        #1;
        n_checks++;
        if (count_o !== 6'd30 || overflow_o !== 1'b1)
            $display("[TB] FAIL ovf_pop_proceeds: got count=%0d ovf=%0b expected count=30 ovf=1", count_o, overflow_o);
        else n_pass++;
        for (int i = 0; i < DW; i++) begin
            n_checks++;
            if (lane(i) !== q[i]) $display("[TB] FAIL ovf_lane%0d: got %0d expected %0d", i, lane(i), q[i]);
            else n_pass++;
        end
        drive(4'b1111, 4'b1111, fe, 1'b1);
        advance();
        drive('0, '0, '0, 1'b0);
        #1;
        n_checks++;
        if (count_o !== 6'd32 || overflow_o !== 1'b0)
            $display("[TB] FAIL flush_state: got count=%0d ovf=%0b expected count=32 ovf=0", count_o, overflow_o);
        else n_pass++;
        for (int i = 0; i < DW; i++) begin
            n_checks++;
            if (lane(i) !== i) $display("[TB] FAIL flush_lane%0d: got %0d expected %0d", i, lane(i), i);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [IW*INDEX-1:0] fe;
        do_reset();
        drive('0, 4'b0001, {15'd0, 5'd3}, 1'b0);
        advance();
        drive(4'b1111, '0, '0, 1'b0);
        advance();
        fe = '0;
        fe[4:0] = 5'(take_inuse());
        drive(4'b0011, 4'b0001, fe, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (count_o !== 6'd32 || overflow_o !== 1'b0)
            $display("[TB] FAIL async_reset_state: got count=%0d ovf=%0b expected count=32 ovf=0", count_o, overflow_o);
        else n_pass++;
        for (int i = 0; i < DW; i++) begin
            n_checks++;
            if (lane(i) !== i) $display("[TB] FAIL async_reset_lane%0d: got %0d expected %0d", i, lane(i), i);
            else n_pass++;
        end
        drive('0, '0, '0, 1'b0);
        #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (count_o !== 6'd32) $display("[TB] FAIL async_release_count: got %0d expected 32", count_o);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        drive('0, '0, '0, 1'b0);
        test_reset();
        test_first_pop();
        test_drain_stall();
        test_sparse_push();
        test_wrap_traffic();
        test_overflow();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
